// File: rtl/fir_serial_mac.sv
// Serial multiply-accumulate engine for one equalizer band: shifts each accepted
// sample into the external delay pipeline, sweeps every tap, then rounds and saturates.
module fir_serial_mac #(
    parameter int unsigned NUM_TAPS  = 64,
    parameter int unsigned COEF_W    = 16,
    parameter int unsigned ACC_W     = 40,
    parameter int unsigned OUT_SHIFT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [15:0]       sample_in,
    output logic signed [15:0]       filter_in,
    output logic                     phase_0,
    output logic [5:0]               current_count,
    input  logic signed [15:0]       delay_filter_in,
    input  logic signed [COEF_W-1:0] coef_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [15:0]       filter_out,
    output logic                     busy
);

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned CNT_W    = 6;
    localparam int unsigned PROD_W   = SAMPLE_W + COEF_W;

    localparam logic [CNT_W-1:0]        LAST_TAP = CNT_W'(NUM_TAPS - 1);
    localparam logic signed [ACC_W-1:0] ROUND_C  = ACC_W'(64'd1 << (OUT_SHIFT - 1));
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_FINISH,
        S_OUT
    } state_t;

    state_t                     state_q, state_d;
    logic                       in_ready_q, in_ready_d;
    logic                       phase_0_q, phase_0_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic signed [SAMPLE_W-1:0] filter_in_q, filter_in_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic                       out_valid_q, out_valid_d;
    logic signed [SAMPLE_W-1:0] filter_out_q, filter_out_d;
    logic                       busy_q, busy_d;

    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    rounded;

    // Full-width tap product, sign-extended into the accumulator width
    always_comb begin
        prod     = delay_filter_in * coef_in;
        prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        rounded  = (acc_q + ROUND_C) >>> OUT_SHIFT;
    end

    always_comb begin
        state_d      = state_q;
        in_ready_d   = in_ready_q;
        phase_0_d    = 1'b0;
        count_d      = count_q;
        filter_in_d  = filter_in_q;
        acc_d        = acc_q;
        out_valid_d  = out_valid_q;
        filter_out_d = filter_out_q;
        busy_d       = busy_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    filter_in_d = sample_in;
                    in_ready_d  = 1'b0;
                    phase_0_d   = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                count_d = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                // Tap 0 overwrites the accumulator so no separate clear cycle is needed
                acc_d = (count_q == '0) ? prod_ext : (acc_q + prod_ext);
                if (count_q == LAST_TAP) begin
                    count_d = '0;
                    state_d = S_FINISH;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            S_FINISH: begin
                if (rounded > SAT_MAX) begin
                    filter_out_d = SAMPLE_W'(SAT_MAX);
                end else if (rounded < SAT_MIN) begin
                    filter_out_d = SAMPLE_W'(SAT_MIN);
                end else begin
                    filter_out_d = SAMPLE_W'(rounded);
                end
                out_valid_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                count_d     = '0;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            in_ready_q   <= 1'b1;
            phase_0_q    <= 1'b0;
            count_q      <= '0;
            filter_in_q  <= '0;
            acc_q        <= '0;
            out_valid_q  <= 1'b0;
            filter_out_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            phase_0_q    <= phase_0_d;
            count_q      <= count_d;
            filter_in_q  <= filter_in_d;
            acc_q        <= acc_d;
            out_valid_q  <= out_valid_d;
            filter_out_q <= filter_out_d;
            busy_q       <= busy_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign phase_0       = phase_0_q;
    assign current_count = count_q;
    assign filter_in     = filter_in_q;
    assign out_valid     = out_valid_q;
    assign filter_out    = filter_out_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_fir_serial_mac.sv
// Bench for fir_serial_mac: models the band delay pipeline and coefficient ROM,
// and predicts each output from the history of accepted samples.
module tb_fir_serial_mac;

    localparam int NTAPS = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] sample_in;
    logic signed [15:0] filter_in;
    logic               phase_0;
    logic [5:0]         current_count;
    logic signed [15:0] delay_filter_in;
    logic signed [15:0] coef_in;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] filter_out;
    logic               busy;

    int n_cmp = 0;
    int n_err = 0;

    logic signed [15:0] coef_rom [NTAPS];
    logic signed [15:0] pipe     [NTAPS];
    longint             hist[$];

    always #5 clk = ~clk;

    fir_serial_mac dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .sample_in      (sample_in),
        .filter_in      (filter_in),
        .phase_0        (phase_0),
        .current_count  (current_count),
        .delay_filter_in(delay_filter_in),
        .coef_in        (coef_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .filter_out     (filter_out),
        .busy           (busy)
    );

    // Band delay pipeline and coefficient ROM seen by the engine
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) pipe[i] <= '0;
        end else if (phase_0) begin
            pipe[0] <= filter_in;
            for (int i = 1; i < NTAPS; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign delay_filter_in = pipe[current_count];
    assign coef_in         = coef_rom[current_count];

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected band output: dot product of the last NTAPS samples with the ROM,
    // round half up at 2^-15, clamp to 16-bit signed.
    function automatic longint ref_out();
        longint acc;
        longint r;
        acc = 0;
        for (int k = 0; k < NTAPS; k++)
            if (k < hist.size()) acc += hist[k] * longint'(coef_rom[k]);
        r = (acc + 64'sd16384) >>> 15;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    task automatic set_coef(input int v);
        for (int k = 0; k < NTAPS; k++) coef_rom[k] = 16'(v);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, longint'(in_ready), 1);
        check({tag, "_phase_0"}, longint'(phase_0), 0);
        check({tag, "_count"}, longint'(current_count), 0);
        check({tag, "_filter_in"}, longint'(filter_in), 0);
        check({tag, "_out_valid"}, longint'(out_valid), 0);
        check({tag, "_filter_out"}, longint'(filter_out), 0);
        check({tag, "_busy"}, longint'(busy), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hist.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at a negedge after the acceptance edge.
    task automatic send(input logic signed [15:0] s);
        int n;
        n = 0;
        in_valid  = 1'b1;
        sample_in = s;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("send_timeout", 1, 0);
        @(posedge clk);
        hist.push_front(longint'(s));
        if (hist.size() > NTAPS) void'(hist.pop_back());
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic recv(input string tag, input int hold, output longint got);
        int n;
        longint exp;
        n = 0;
        exp = ref_out();
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check({tag, "_timeout"}, 1, 0);
        got = longint'(filter_out);
        check(tag, got, exp);
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_drop"}, longint'(out_valid), 0);
    endtask

    initial begin
        longint got;
        longint exp;
        int     seen;
        int     n;

        rst = 1'b1;
        in_valid = 1'b0;
        sample_in = '0;
        out_ready = 1'b1;
        set_coef(0);
        repeat (3) @(negedge clk);
        check_reset_vals("rst_held");
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_rel");

        // Latency profile on the first impulse sample
        set_coef(16384);
        check("lat_in_ready", longint'(in_ready), 1);
        in_valid  = 1'b1;
        sample_in = 16'sd32767;
        @(posedge clk);
        hist.push_front(32767);
        for (int c = 0; c < 68; c++) begin
            @(negedge clk);
            if (c == 0) in_valid = 1'b0;
            check($sformatf("lat_phase0_c%0d", c), longint'(phase_0), (c == 0) ? 1 : 0);
            check($sformatf("lat_count_c%0d", c), longint'(current_count),
                  (c >= 1 && c <= 64) ? longint'(c - 1) : 0);
            check($sformatf("lat_busy_c%0d", c), longint'(busy), (c <= 65) ? 1 : 0);
            check($sformatf("lat_ovalid_c%0d", c), longint'(out_valid), (c == 66) ? 1 : 0);
            check($sformatf("lat_iready_c%0d", c), longint'(in_ready), (c >= 67) ? 1 : 0);
            if (c == 66) check("impulse_1", longint'(filter_out), 16384);
        end

        for (int i = 2; i <= 65; i++) begin
            send(16'sd0);
            recv($sformatf("impulse_%0d", i), 0, got);
            check($sformatf("impulse_const_%0d", i), got, (i <= 64) ? 16384 : 0);
        end

        // Saturation at both rails
        do_reset();
        set_coef(32767);
        for (int i = 0; i < NTAPS; i++) begin
            send(16'sd32767);
            recv("sat_pos", 0, got);
        end
        check("sat_pos_final", got, 32767);
        for (int i = 0; i < NTAPS; i++) begin
            send(-16'sd32768);
            recv("sat_neg", 0, got);
        end
        check("sat_neg_final", got, -32768);

        // Rounding on small negative impulses
        do_reset();
        set_coef(16384);
        send(-16'sd1);
        recv("round_m1", 0, got);
        check("round_m1_const", got, 0);
        do_reset();
        send(-16'sd3);
        recv("round_m3", 0, got);
        check("round_m3_const", got, -1);

        // Backpressure: output held, input ignored
        do_reset();
        out_ready = 1'b0;
        send(16'sd1234);
        exp = ref_out();
        n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("bp_timeout", 1, 0);
        for (int i = 0; i < 10; i++) begin
            check("bp_ovalid", longint'(out_valid), 1);
            check("bp_fout", longint'(filter_out), exp);
            check("bp_iready", longint'(in_ready), 0);
            if (i == 3) begin
                in_valid  = 1'b1;
                sample_in = 16'sd777;
            end
            if (i == 4) in_valid = 1'b0;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_ovalid", longint'(out_valid), 0);
        check("bp_release_iready", longint'(in_ready), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_not_queued_busy", longint'(busy), 0);
            check("bp_not_queued_ovalid", longint'(out_valid), 0);
        end

        // Reset in the middle of the tap sweep
        in_valid  = 1'b1;
        sample_in = 16'sd20000;
        n = 0;
        while (current_count != 6'd30 && n < 300) begin
            @(negedge clk);
            if (!in_ready) in_valid = 1'b0;
            n++;
        end
        if (n >= 300) check("midrst_timeout", 1, 0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        hist.delete();
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst_no_out", seen, 0);
        send(16'sd32767);
        recv("midrst_impulse", 0, got);
        check("midrst_impulse_const", got, 16384);

        // Randomized samples, coefficients and backpressure
        do_reset();
        for (int k = 0; k < NTAPS; k++) coef_rom[k] = 16'($urandom);
        for (int i = 0; i < 40; i++) begin
            out_ready = 1'b0;
            case ($urandom_range(0, 4))
                0:       send(16'sd32767);
                1:       send(-16'sd32768);
                default: send(16'($urandom));
            endcase
            recv("rand", int'($urandom_range(0, 3)), got);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fir_serial_mac.md
# fir_serial_mac

- Serial multiply-accumulate engine that reads the 64-deep sample delay pipeline of one equalizer band filter.
- Per accepted audio sample it:
  - drives the sample into the pipeline with a one-cycle `phase_0` shift pulse;
  - sweeps `current_count` across every tap, accumulating `delay_filter_in × coef_in`;
  - rounds, scales and saturates the sum to a 16-bit band output.
- Sits between the band's input sample stream (valid/ready) and the band gain/summing stage (valid/ready), one instance per band.

## Interface
Parameters:
- NUM_TAPS, 64, taps per sample; equals the delay pipeline depth.
- COEF_W, 16, signed coefficient width (Q1.15).
- ACC_W, 40, signed accumulator width.
- OUT_SHIFT, 15, right shift applied to the accumulator to form the output.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  sample_in valid.
- in_ready  out  1  block accepts a sample.
- sample_in  in  16  signed input sample.
- filter_in  out  16  registered sample to delay pipeline input.
- phase_0  out  1  one-cycle shift pulse to delay pipeline.
- current_count  out  6  tap index; selects the pipeline stage and addresses the coefficient ROM.
- delay_filter_in  in  16  signed pipeline stage at current_count; combinational same cycle.
- coef_in  in  COEF_W  signed coefficient at current_count; combinational same cycle.
- out_valid  out  1  filter_out valid.
- out_ready  in  1  downstream accepts.
- filter_out  out  16  signed saturated result.
- busy  out  1  high in LOAD, MAC, FINISH.

## Operation
- Reset values: state IDLE, in_ready 1, phase_0 0, current_count 0, filter_in 0, acc 0, out_valid 0, filter_out 0, busy 0.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: register sample_in into filter_in, go to LOAD.
- LOAD (1 cycle):
  - phase_0=1, current_count=0; the pipeline shifts at this cycle's closing edge.
  - Go to MAC.
- MAC (NUM_TAPS cycles):
  - current_count runs 0..NUM_TAPS-1.
  - Product = delay_filter_in × coef_in: signed 16×COEF_W, full width, sign-extended to ACC_W.
  - At count 0: acc <= product (implicit clear). Otherwise acc <= acc + product.
  - After count NUM_TAPS-1: current_count returns to 0, go to FINISH.
- FINISH (1 cycle):
  - r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT (arithmetic shift, round half up).
  - Saturate r to [-32768, 32767] into filter_out; set out_valid=1; go to OUT.
- OUT:
  - out_valid and filter_out are held stable until out_valid&out_ready.
  - On that edge: out_valid<=0, go to IDLE.
- in_ready=0 in every state except IDLE. in_valid outside IDLE is ignored, not queued.
- phase_0 is high only in LOAD. current_count is 0 outside MAC.
- An in_valid/out_ready coincidence in OUT does not accept the input; the input is accepted at the earliest in the following IDLE cycle.
- Reset mid-operation:
  - Immediate return to reset values; the partial acc is discarded and no out_valid is produced.
  - The shared rst also zeros the delay pipeline.

## Timing
- Acceptance edge t.
- LOAD occupies cycle t..t+1; phase_0 is high for exactly that cycle.
- MAC counts 0..63 on cycles t+1..t+65.
- FINISH occupies cycle t+65..t+66. out_valid rises at edge t+66, so latency is NUM_TAPS+2 cycles.
- With out_ready=1: out_valid lasts 1 cycle, in_ready rises at edge t+67, and the next acceptance is possible at edge t+68.
- Minimum period is NUM_TAPS+4 cycles per sample.
- Worst case |acc| = 64·32768·32768 = 2^36, which fits in ACC_W=40 without overflow.

## Test plan
- Impulse: all coef_in=16384, input 32767 then 64 zeros:
  - outputs 1..64 = 16384 (16383.5 rounds up);
  - output 65 = 0.
- Latency: in_valid&in_ready at edge t -> phase_0 high only during cycle t..t+1, current_count 0..63 on cycles t+1..t+65, out_valid rises at t+66, busy high for t..t+66.
- Saturation:
  - coef 32767, 64 samples of 32767 -> filter_out 32767;
  - coef 32767, 64 samples of -32768 -> filter_out -32768.
- Rounding: coef 16384, impulse -1 -> filter_out 0; impulse -3 -> filter_out -1.
- Backpressure: out_ready low 10 cycles after out_valid -> filter_out and out_valid stable, in_ready 0, pulsed in_valid ignored; raising out_ready -> in_ready 1 one cycle later.
- Reset mid-MAC at current_count 30 -> all outputs at reset values, no out_valid; the next impulse 32767 with coef 16384 yields 16384.
